// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding,
// default widths and the MIPS opcode constants decoded by the top level.
package pipe_pkg;

    // Default widths
    localparam int PC_W_DEF      = 10;
    localparam int RA_W_DEF      = 5;
    localparam int CNT_W_DEF     = 16;
    localparam int DRAIN_CYC_DEF = 3;
    localparam int WB_FWD_DEF    = 1;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_REFILL = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

    // Number of pipeline stages whose destination is compared against decode
    localparam int N_DEST_STAGES = 3;

endpackage

// File: rtl/hazard_detect.sv
// Combinational read-after-write hazard check between the decode-stage
// sources and the destinations of execute, memory and writeback.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RA_W   = RA_W_DEF,
    parameter int WB_FWD = WB_FWD_DEF
) (
    input  logic [RA_W-1:0] dec_rs,
    input  logic [RA_W-1:0] dec_rt,
    input  logic            dec_use_rs,
    input  logic            dec_use_rt,
    input  logic [RA_W-1:0] ex_dest,
    input  logic [RA_W-1:0] mem_dest,
    input  logic [RA_W-1:0] wb_dest,
    input  logic            ex_wen,
    input  logic            mem_wen,
    input  logic            wb_wen,
    output logic            hazard
);

    logic [RA_W-1:0]          dest_arr [N_DEST_STAGES];
    logic [N_DEST_STAGES-1:0] wen_arr;
    logic [N_DEST_STAGES-1:0] stage_hit;
    logic [N_DEST_STAGES-1:0] stage_enable;

    // Index 0 = execute, 1 = memory, 2 = writeback
    always_comb begin
        dest_arr[0] = ex_dest;
        dest_arr[1] = mem_dest;
        dest_arr[2] = wb_dest;
        wen_arr     = {wb_wen, mem_wen, ex_wen};
        // With a write-through register file the writeback value is already
        // visible to decode, so that stage never causes a stall.
        stage_enable = {(WB_FWD == 0), 1'b1, 1'b1};
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DEST_STAGES; gi++) begin : g_stage
            logic rs_hit;
            logic rt_hit;
            // Register 0 is hardwired to zero and never creates a dependency
            always_comb begin
                rs_hit = dec_use_rs && (dec_rs != '0) && (dec_rs == dest_arr[gi]);
                rt_hit = dec_use_rt && (dec_rt != '0) && (dec_rt == dest_arr[gi]);
                stage_hit[gi] = wen_arr[gi] && stage_enable[gi] && (rs_hit || rt_hit);
            end
        end
    endgenerate

    // Any enabled stage match stalls decode
    always_comb begin
        hazard = |stage_hit;
    end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline control: owns the PC, decides advance / stall / flush each cycle,
// inserts the refill bubble for the synchronous ROM and runs halt/resume.
module pipe_sequencer
    import pipe_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RA_W      = RA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int WB_FWD    = WB_FWD_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RA_W-1:0]  dec_rs,
    input  logic [RA_W-1:0]  dec_rt,
    input  logic             dec_use_rs,
    input  logic             dec_use_rt,
    input  logic             dec_halt,
    input  logic [RA_W-1:0]  ex_dest,
    input  logic [RA_W-1:0]  mem_dest,
    input  logic [RA_W-1:0]  wb_dest,
    input  logic             ex_wen,
    input  logic             mem_wen,
    input  logic             wb_wen,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic             if_capture,
    output logic             dec_flush,
    output logic             ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc;
    logic             flush_inc;
    logic             hazard;

    hazard_detect #(
        .RA_W   (RA_W),
        .WB_FWD (WB_FWD)
    ) u_hazard (
        .dec_rs     (dec_rs),
        .dec_rt     (dec_rt),
        .dec_use_rs (dec_use_rs),
        .dec_use_rt (dec_use_rt),
        .ex_dest    (ex_dest),
        .mem_dest   (mem_dest),
        .wb_dest    (wb_dest),
        .ex_wen     (ex_wen),
        .mem_wen    (mem_wen),
        .wb_wen     (wb_wen),
        .hazard     (hazard)
    );

    // State, PC, drain counter and statistics registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_REFILL;
            pc_q        <= '0;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state, next PC and counter events
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drain_d   = drain_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            ST_REFILL: begin
                // A redirect here restarts the refill at the new target
                if (redirect) begin
                    pc_d      = redirect_pc;
                    flush_inc = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d      = redirect_pc;
                    flush_inc = 1'b1;
                    state_d   = ST_REFILL;
                end else if (hazard) begin
                    stall_inc = 1'b1;
                end else if (dec_halt) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            ST_DRAIN: begin
                // An older branch still in execute cancels the halt
                if (redirect) begin
                    pc_d      = redirect_pc;
                    flush_inc = 1'b1;
                    state_d   = ST_REFILL;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_REFILL;
                end
            end
            default: begin
                state_d = ST_REFILL;
            end
        endcase
    end

    // Saturating statistics counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline strobes; all held low while reset is asserted
    always_comb begin
        if_capture = 1'b0;
        dec_flush  = 1'b0;
        ex_bubble  = 1'b1;
        halted     = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_REFILL: begin
                    dec_flush = redirect;
                end
                ST_RUN: begin
                    if (redirect) begin
                        dec_flush = 1'b1;
                    end else if (hazard) begin
                        dec_flush = 1'b0;
                    end else if (dec_halt) begin
                        dec_flush = 1'b1;
                    end else begin
                        if_capture = 1'b1;
                        ex_bubble  = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    dec_flush = redirect;
                end
                ST_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    dec_flush = 1'b0;
                end
            endcase
        end else begin
            ex_bubble = 1'b0;
        end
    end

    assign pc        = pc_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer. A second instance with WB_FWD=0 and
// 2-bit counters shares the stimulus to cover writeback stalls and saturation.
module tb_pipe_sequencer;

    logic       clock;
    logic       reset;
    logic [4:0] dec_rs, dec_rt, ex_dest, mem_dest, wb_dest;
    logic       dec_use_rs, dec_use_rt, dec_halt;
    logic       ex_wen, mem_wen, wb_wen;
    logic       redirect;
    logic [9:0] redirect_pc;
    logic       resume;

    logic [9:0]  pc_a;
    logic        if_capture_a, dec_flush_a, ex_bubble_a, halted_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;

    logic [9:0]  pc_b;
    logic        if_capture_b, dec_flush_b, ex_bubble_b, halted_b;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_sequencer dut (
        .clock(clock), .reset(reset),
        .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_halt(dec_halt),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
        .pc(pc_a), .if_capture(if_capture_a), .dec_flush(dec_flush_a),
        .ex_bubble(ex_bubble_a), .halted(halted_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    pipe_sequencer #(.CNT_W(2), .WB_FWD(0)) dut_b (
        .clock(clock), .reset(reset),
        .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_halt(dec_halt),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
        .pc(pc_b), .if_capture(if_capture_b), .dec_flush(dec_flush_b),
        .ex_bubble(ex_bubble_b), .halted(halted_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock edge and settle just after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        dec_rs = '0; dec_rt = '0; dec_use_rs = 0; dec_use_rt = 0; dec_halt = 0;
        ex_dest = '0; mem_dest = '0; wb_dest = '0;
        ex_wen = 0; mem_wen = 0; wb_wen = 0;
        redirect = 0; redirect_pc = '0; resume = 0;
    endtask

    // Hold reset over two edges, release just after an edge -> REFILL at pc 0
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        // Reset state
        check_eq("rst_pc", pc_a, 0);
        check_eq("rst_stall", stall_cnt_a, 0);
        check_eq("rst_flush", flush_cnt_a, 0);
        check_eq("rst_ex_bubble", ex_bubble_a, 0);
        check_eq("rst_if_capture", if_capture_a, 0);
        check_eq("rst_halted", halted_a, 0);

        // Sequential fetch: one REFILL, then pc 0,1,2,3 with capture
        do_reset();
        check_eq("refill_if_capture", if_capture_a, 0);
        check_eq("refill_ex_bubble", ex_bubble_a, 1);
        check_eq("refill_pc", pc_a, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("seq_pc%0d", k), pc_a, k);
            check_eq($sformatf("seq_cap%0d", k), if_capture_a, 1);
        end

        // Hazard: ex match then mem match -> two stalls at pc 3
        dec_rs = 5'd8; dec_use_rs = 1; ex_dest = 5'd8; ex_wen = 1;
        #1;
        check_eq("haz_ex_capture", if_capture_a, 0);
        check_eq("haz_ex_bubble", ex_bubble_a, 1);
        tick();
        check_eq("haz_ex_pc", pc_a, 3);
        check_eq("haz_ex_stall", stall_cnt_a, 1);
        ex_wen = 0; mem_dest = 5'd8; mem_wen = 1;
        #1;
        check_eq("haz_mem_bubble", ex_bubble_a, 1);
        tick();
        check_eq("haz_mem_pc", pc_a, 3);
        check_eq("haz_mem_stall", stall_cnt_a, 2);
        clear_inputs();
        #1;
        check_eq("haz_clear_capture", if_capture_a, 1);
        tick();
        check_eq("haz_resume_pc", pc_a, 4);

        // Register 0 never matches
        dec_rs = 5'd0; dec_use_rs = 1; ex_dest = 5'd0; ex_wen = 1;
        #1;
        check_eq("r0_capture", if_capture_a, 1);
        tick();
        check_eq("r0_pc", pc_a, 5);
        check_eq("r0_stall", stall_cnt_a, 2);
        clear_inputs();

        // Writeback match: stalls only without write-through; 2-bit counter saturates
        dec_rt = 5'd5; dec_use_rt = 1; wb_dest = 5'd5; wb_wen = 1;
        #1;
        check_eq("wb_fwd1_capture", if_capture_a, 1);
        check_eq("wb_fwd0_capture", if_capture_b, 0);
        tick();
        check_eq("wb_fwd1_pc", pc_a, 6);
        check_eq("wb_fwd0_pc", pc_b, 5);
        check_eq("wb_fwd0_stall", stall_cnt_b, 3);
        tick();
        check_eq("sat_stall", stall_cnt_b, 3);
        check_eq("wb_fwd1_stall", stall_cnt_a, 2);
        clear_inputs();

        // Redirect together with a hazard: redirect wins
        do_reset();
        tick();
        redirect = 1; redirect_pc = 10'h3F0;
        dec_rs = 5'd3; dec_use_rs = 1; ex_dest = 5'd3; ex_wen = 1;
        #1;
        check_eq("redir_dec_flush", dec_flush_a, 1);
        check_eq("redir_ex_bubble", ex_bubble_a, 1);
        tick();
        check_eq("redir_pc", pc_a, 10'h3F0);
        check_eq("redir_flush_cnt", flush_cnt_a, 1);
        check_eq("redir_stall_cnt", stall_cnt_a, 0);
        clear_inputs();
        #1;
        check_eq("redir_refill_capture", if_capture_a, 0);
        check_eq("redir_refill_bubble", ex_bubble_a, 1);
        tick();
        check_eq("redir_run_pc", pc_a, 10'h3F0);
        check_eq("redir_run_capture", if_capture_a, 1);
        tick();
        check_eq("redir_next_pc", pc_a, 10'h3F1);

        // PC wrap at 0x3FF
        redirect = 1; redirect_pc = 10'h3FF;
        tick();
        clear_inputs();
        check_eq("wrap_flush_cnt", flush_cnt_a, 2);
        tick();
        check_eq("wrap_pc_top", pc_a, 10'h3FF);
        tick();
        check_eq("wrap_pc_zero", pc_a, 0);

        // Halt at pc 5: three DRAIN cycles, HALTED, resume
        do_reset();
        tick();
        for (int k = 0; k < 5; k++) tick();
        check_eq("halt_at_pc", pc_a, 5);
        dec_halt = 1;
        #1;
        check_eq("halt_dec_flush", dec_flush_a, 1);
        check_eq("halt_ex_bubble", ex_bubble_a, 1);
        check_eq("halt_capture", if_capture_a, 0);
        tick();
        dec_halt = 0;
        #1;
        check_eq("drain0_halted", halted_a, 0);
        check_eq("drain0_bubble", ex_bubble_a, 1);
        tick();
        tick();
        check_eq("drain2_halted", halted_a, 0);
        check_eq("drain2_pc", pc_a, 5);
        tick();
        check_eq("halted_flag", halted_a, 1);
        check_eq("halted_pc", pc_a, 5);
        redirect = 1; redirect_pc = 10'h200;
        tick();
        redirect = 0;
        check_eq("halted_ignore_redir_pc", pc_a, 5);
        check_eq("halted_ignore_redir_flag", halted_a, 1);
        resume = 1;
        tick();
        resume = 0;
        #1;
        check_eq("resume_halted", halted_a, 0);
        check_eq("resume_refill_capture", if_capture_a, 0);
        tick();
        check_eq("resume_pc", pc_a, 5);
        check_eq("resume_capture", if_capture_a, 1);
        tick();
        check_eq("resume_next_pc", pc_a, 6);

        // Redirect during DRAIN cancels the halt
        dec_halt = 1;
        tick();
        dec_halt = 0;
        redirect = 1; redirect_pc = 10'h100;
        #1;
        check_eq("drain_redir_flush", dec_flush_a, 1);
        tick();
        clear_inputs();
        check_eq("drain_redir_pc", pc_a, 10'h100);
        check_eq("drain_redir_flush_cnt", flush_cnt_a, 1);
        tick();
        check_eq("drain_redir_run_cap", if_capture_a, 1);
        check_eq("drain_redir_halted", halted_a, 0);

        // Reset asserted in DRAIN aborts immediately
        dec_halt = 1;
        tick();
        dec_halt = 0;
        tick();
        reset = 1;
        #1;
        check_eq("midrst_pc", pc_a, 0);
        check_eq("midrst_flush_cnt", flush_cnt_a, 0);
        tick();
        reset = 0;
        #1;
        check_eq("midrst_refill_bubble", ex_bubble_a, 1);
        check_eq("midrst_refill_capture", if_capture_a, 0);
        tick();
        check_eq("midrst_first_pc", pc_a, 0);
        check_eq("midrst_first_capture", if_capture_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
Central control for the 5-stage MIPS pipeline (fetch/decode/execute/memory/writeback). Owns the program counter and decides each cycle whether the pipeline advances, stalls or flushes. Also handles the refill bubble required by the synchronous instruction ROM and a halt/resume sequence. The top level drives its IR pipeline registers and ROM address from this block's outputs; the block contains no datapath beyond PC and counters.

Parameters:
PC_W, 10, program counter / ROM address width
RA_W, 5, register address width
CNT_W, 16, width of the statistics counters
DRAIN_CYC, 3, cycles spent in DRAIN before entering HALTED
WB_FWD, 1, 1 = register file write-through; a writeback destination match does not stall

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
dec_rs  in  RA_W  decode-stage source register 1
dec_rt  in  RA_W  decode-stage source register 2
dec_use_rs  in  1  decode instruction reads rs
dec_use_rt  in  1  decode instruction reads rt
dec_halt  in  1  decode holds a halt instruction
ex_dest / mem_dest / wb_dest  in  RA_W each  destination register of that stage
ex_wen / mem_wen / wb_wen  in  1 each  that stage will write its destination
redirect  in  1  execute resolved a taken branch or jump
redirect_pc  in  PC_W  target address
resume  in  1  leave HALTED (level)
pc  out  PC_W  ROM address
if_capture  out  1  decode_IR <= ROM q this cycle
dec_flush  out  1  decode_IR <= 0
ex_bubble  out  1  execute_IR <= 0 instead of decode_IR
halted  out  1  state == HALTED
stall_cnt  out  CNT_W  cycles spent stalled on hazards
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Reset (asynchronous, active-high): state=REFILL, pc=0, counters=0, all strobes 0. Strobes are combinational from state and inputs; pc, state and counters are registered.
- ROM latency is one cycle. q reflects the pc of the previous edge. REFILL lasts exactly one cycle: pc held, if_capture=0, ex_bubble=1. Next state is RUN.
- Hazard: (dec_use_rs and rs!=0 and rs matches a dest X with X_wen) or the same test for rt, with X in {ex, mem}; wb is included only when WB_FWD=0. Register 0 never matches.
- RUN priority per cycle (highest first): redirect > hazard > dec_halt > advance.
  - redirect: pc<=redirect_pc; dec_flush=1; ex_bubble=1; flush_cnt++; next state REFILL.
  - hazard: pc held; if_capture=0; decode held; ex_bubble=1; stall_cnt++.
  - dec_halt (no hazard): ex_bubble=1 (the halt itself is not issued); dec_flush=1; pc held; next state DRAIN with drain counter=0.
  - advance: pc<=pc+1, wrapping modulo 2^PC_W; if_capture=1.
- DRAIN: ex_bubble=1, if_capture=0, pc held. The drain counter increments each cycle; at DRAIN_CYC-1 go to HALTED. A redirect during DRAIN (an older branch still in execute) cancels the halt and is handled as in RUN, going to REFILL.
- HALTED: halted=1, ex_bubble=1, pc held (points past the halt). resume=1 goes to REFILL. Redirect is ignored in HALTED.
- Redirect in REFILL is honoured (pc<=redirect_pc, stay in REFILL one more cycle).
- Counters saturate at all-ones and are cleared only by reset.
- Reset asserted mid-operation aborts any state immediately. First fetch after release is pc=0.

Decomposition:
- Shared package pipe_pkg: state encoding (REFILL, RUN, DRAIN, HALTED), opcode constants for R-type/addi/lw/sw/beq/j, and the default widths.
- One sub-module, hazard_detect: purely combinational source/destination compare, parameterised on WB_FWD. FSM, PC and counters stay in pipe_sequencer.

Test Plan:
- Release reset, no hazards, no redirects -> one REFILL cycle, then pc sequence 0,1,2,3…; if_capture=1 from the second cycle onward.
- Hazard: dec_rs=8 with use_rs, ex_dest=8 and ex_wen for 1 cycle, then mem_dest=8 for 1 cycle -> 2 stall cycles with pc frozen, ex_bubble=1, stall_cnt=2; rs=0 with ex_dest=0 -> no stall.
- WB_FWD=0, wb_dest match -> extra stall cycle; WB_FWD=1 -> none.
- redirect=1, redirect_pc=0x3F0 during RUN -> pc=0x3F0 next edge, dec_flush=1, ex_bubble=1, one REFILL cycle, flush_cnt=1; redirect together with a hazard -> redirect wins, stall_cnt unchanged.
- dec_halt at pc=5 -> DRAIN for 3 cycles, then halted=1 with pc held; resume -> REFILL, then fetch continues from the held pc; redirect during DRAIN -> halt cancelled, pc=target.
- Wrap and saturation: pc=0x3FF advances to 0; force stall_cnt to all-ones and add a stall -> remains 0xFFFF; assert reset in DRAIN -> immediate REFILL, pc=0.
